bus_responder: RTL and testbench

Responder side of the 6502 core bus. It decodes `addr`/`RW`/`dor` from the core and returns `din` with 1-cycle registered latency. It owns the RAM, a vector ROM, and a memory-mapped I/O page containing a console TX FIFO and an interval timer. It drives the core's READY and IRQ inputs and replaces the inline BRAM in the top level.

---
 rtl/bus_pkg.sv | 34 +++
 rtl/bus_fifo.sv | 49 ++++
 rtl/bus_responder.sv | 130 +++++++++++++
 tb/tb_bus_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants and the address-region decoder for the 6502 bus responder.
package bus_pkg;

  localparam logic [15:0] IO_TXDATA    = 16'hD000;
  localparam logic [15:0] IO_STATUS    = 16'hD001;
  localparam logic [15:0] IO_RELOAD_LO = 16'hD002;
  localparam logic [15:0] IO_RELOAD_HI = 16'hD003;
  localparam logic [15:0] IO_CTRL      = 16'hD004;
  localparam logic [15:0] IO_IRQCLR    = 16'hD005;
  localparam logic [15:0] IO_COUNT_LO  = 16'hD006;
  localparam logic [15:0] IO_COUNT_HI  = 16'hD007;
  localparam logic [15:0] VEC_NMI      = 16'hFFFA;
  localparam logic [15:0] VEC_RST      = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ      = 16'hFFFE;
  localparam logic [7:0]  IO_PAGE      = 8'hD0;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_IRQ   = 7;
  localparam int CTRL_TEN = 0;
  localparam int CTRL_IEN = 1;

  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_VEC, REG_NONE} region_e;

  function automatic region_e decode_region(input logic [15:0] a, input int ram_depth);
    region_e r;
    if (int'({16'h0000, a}) < ram_depth) r = REG_RAM;
    else if (a[15:8] == IO_PAGE)         r = REG_IO;
    else if (a >= VEC_NMI)               r = REG_VEC;
    else                                 r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// Show-ahead FIFO: dout is the head entry whenever empty is low.
module bus_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO is still legal.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bus_responder.sv
// 6502 bus responder: RAM, vector ROM, console TX FIFO and interval timer with
// registered read data and READY back-pressure on a full console FIFO.
module bus_responder
  import bus_pkg::*;
#(
  parameter int          RAM_DEPTH = 1024,
  parameter logic [15:0] BOOT_ADDR = 16'h00f0,
  parameter logic [15:0] IRQ_ADDR  = 16'h0200,
  parameter int          TX_DEPTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] addr,
  input  logic [7:0]  dor,
  input  logic        RW,
  output logic [7:0]  din,
  output logic        READY,
  output logic        IRQ,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int RAW = $clog2(RAM_DEPTH);

  logic [7:0]  ram_q [RAM_DEPTH];
  logic [7:0]  din_q, rdata;
  logic [15:0] count_q, count_d, reload_q, reload_d, vec;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        irq_pend_q, irq_pend_d, expire;
  logic        wr, wr_tx, tx_push, tx_pop, fifo_full, fifo_empty;
  region_e     region;

  assign region   = decode_region(addr, RAM_DEPTH);
  assign wr       = !RW;
  assign wr_tx    = wr && (addr == IO_TXDATA);
  assign tx_valid = !fifo_empty;
  assign tx_pop   = tx_valid && tx_ready;
  // The core holds the bus while READY is low, so the push simply retries.
  assign READY    = !(wr_tx && fifo_full && !tx_pop);
  assign tx_push  = wr_tx && READY;
  assign IRQ      = irq_pend_q && ctrl_q[CTRL_IEN];
  assign din      = din_q;
  assign vec      = (addr[15:1] == VEC_RST[15:1]) ? BOOT_ADDR : IRQ_ADDR;

  bus_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (tx_push),
    .din   (dor),
    .full  (fifo_full),
    .pop   (tx_pop),
    .dout  (tx_data),
    .empty (fifo_empty)
  );

  always_comb begin
    rdata = 8'h00;
    case (region)
      REG_RAM: rdata = ram_q[addr[RAW-1:0]];
      REG_IO: begin
        case (addr)
          IO_STATUS: begin
            rdata[ST_FULL]  = fifo_full;
            rdata[ST_EMPTY] = fifo_empty;
            rdata[ST_IRQ]   = irq_pend_q;
          end
          IO_RELOAD_LO: rdata = reload_q[7:0];
          IO_RELOAD_HI: rdata = reload_q[15:8];
          IO_CTRL:      rdata = {6'b000000, ctrl_q};
          IO_COUNT_LO:  rdata = count_q[7:0];
          IO_COUNT_HI:  rdata = count_q[15:8];
          default:      rdata = 8'h00;
        endcase
      end
      REG_VEC: rdata = addr[0] ? vec[15:8] : vec[7:0];
      default: rdata = 8'h00;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    reload_d   = reload_q;
    ctrl_d     = ctrl_q;
    irq_pend_d = irq_pend_q;
    expire     = 1'b0;
    if (ctrl_q[CTRL_TEN]) begin
      if (count_q == 16'h0000) begin
        expire  = 1'b1;
        count_d = reload_q;
      end else begin
        count_d = count_q - 16'd1;
      end
    end
    if (wr) begin
      case (addr)
        IO_RELOAD_LO: reload_d[7:0]  = dor;
        IO_RELOAD_HI: reload_d[15:8] = dor;
        IO_CTRL: begin
          ctrl_d = dor[1:0];
          if (dor[CTRL_TEN] && !ctrl_q[CTRL_TEN]) count_d = reload_q;
        end
        IO_IRQCLR: irq_pend_d = 1'b0;
        default: ;
      endcase
    end
    // Expiry is applied last so it beats a same-cycle IRQCLR.
    if (expire) irq_pend_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      din_q      <= 8'h00;
      count_q    <= 16'h0000;
      reload_q   <= 16'h0000;
      ctrl_q     <= 2'b00;
      irq_pend_q <= 1'b0;
    end else begin
      din_q      <= rdata;
      count_q    <= count_d;
      reload_q   <= reload_d;
      ctrl_q     <= ctrl_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr && region == REG_RAM) ram_q[addr[RAW-1:0]] <= dor;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder: memory map, console FIFO
// ordering and stall, timer interrupt timing and asynchronous reset.
module tb_bus_responder;

  localparam logic [15:0] IDLE_ADDR = 16'hC000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] addr;
  logic [7:0]  dor;
  logic        RW;
  logic [7:0]  din;
  logic        READY;
  logic        IRQ;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  bus_responder #(
    .RAM_DEPTH (1024),
    .BOOT_ADDR (16'h00f0),
    .IRQ_ADDR  (16'h0200),
    .TX_DEPTH  (8)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .addr     (addr),
    .dor      (dor),
    .RW       (RW),
    .din      (din),
    .READY    (READY),
    .IRQ      (IRQ),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge i_clk);
    addr = a;
    dor  = d;
    RW   = 1'b0;
    @(posedge i_clk);
    #1;
    RW   = 1'b1;
    addr = IDLE_ADDR;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge i_clk);
    addr = a;
    RW   = 1'b1;
    @(posedge i_clk);
    #1;
    d    = din;
    addr = IDLE_ADDR;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic tx_write(input logic [7:0] d);
    bus_write(16'hD000, d);
    exp_q.push_back(d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic irq_seen;
    i_rst    = 1'b1;
    addr     = IDLE_ADDR;
    dor      = 8'h00;
    RW       = 1'b1;
    tx_ready = 1'b0;
    #1;
    check("rst_din", {8'h00, din}, 16'h0000);
    check("rst_ready", {15'h0, READY}, 16'h1);
    check("rst_irq", {15'h0, IRQ}, 16'h0);
    check("rst_tx_valid", {15'h0, tx_valid}, 16'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    read_check("rst_status", 16'hD001, 8'h02);

    // RAM and memory map
    bus_write(16'h0000, 8'h33);
    bus_write(16'h0010, 8'h5A);
    bus_write(16'h03FF, 8'hC7);
    read_check("ram_0010", 16'h0010, 8'h5A);
    read_check("ram_03ff", 16'h03FF, 8'hC7);
    read_check("ram_0000", 16'h0000, 8'h33);
    read_check("ram_oob_0400", 16'h0400, 8'h00);
    read_check("vec_fffa", 16'hFFFA, 8'h00);
    read_check("vec_fffb", 16'hFFFB, 8'h02);
    read_check("vec_fffc", 16'hFFFC, 8'hF0);
    read_check("vec_fffd", 16'hFFFD, 8'h00);
    read_check("vec_fffe", 16'hFFFE, 8'h00);
    read_check("vec_ffff", 16'hFFFF, 8'h02);
    read_check("unmapped_d008", 16'hD008, 8'h00);
    read_check("txdata_read", 16'hD000, 8'h00);

    // Reload readback, enable load, then disable freezes count one step later
    bus_write(16'hD002, 8'h34);
    bus_write(16'hD003, 8'h12);
    read_check("reload_lo", 16'hD002, 8'h34);
    read_check("reload_hi", 16'hD003, 8'h12);
    bus_write(16'hD004, 8'h01);
    bus_write(16'hD004, 8'h00);
    read_check("count_lo_frozen", 16'hD006, 8'h33);
    read_check("count_hi_frozen", 16'hD007, 8'h12);
    read_check("ctrl_read", 16'hD004, 8'h00);

    // FIFO order
    tx_write(8'h41);
    tx_write(8'h42);
    read_check("status_two_queued", 16'hD001, 8'h00);
    @(negedge i_clk);
    tx_ready = 1'b1;
    check("tx_head_41", {8'h00, tx_data}, {8'h00, exp_q.pop_front()});
    @(posedge i_clk);
    #1;
    check("tx_valid_after_pop1", {15'h0, tx_valid}, 16'h1);
    check("tx_head_42", {8'h00, tx_data}, {8'h00, exp_q.pop_front()});
    @(posedge i_clk);
    #1;
    tx_ready = 1'b0;
    check("tx_valid_drained", {15'h0, tx_valid}, 16'h0);
    read_check("status_drained", 16'hD001, 8'h02);

    // FIFO stall
    for (int i = 1; i <= 8; i++) tx_write(8'(i));
    read_check("status_full", 16'hD001, 8'h01);
    @(negedge i_clk);
    addr = 16'hD000;
    dor  = 8'h09;
    RW   = 1'b0;
    #1;
    check("stall_ready_low", {15'h0, READY}, 16'h0);
    repeat (5) begin
      @(posedge i_clk);
      #1;
      check("stall_hold", {15'h0, READY}, 16'h0);
    end
    @(negedge i_clk);
    tx_ready = 1'b1;
    #1;
    check("stall_release_ready", {15'h0, READY}, 16'h1);
    check("stall_release_head", {8'h00, tx_data}, {8'h00, exp_q[0]});
    @(posedge i_clk);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h09);
    #1;
    tx_ready = 1'b0;
    RW       = 1'b1;
    addr     = IDLE_ADDR;
    read_check("status_full_after_swap", 16'hD001, 8'h01);
    tx_ready = 1'b1;
    for (int n = 0; n < 8 && exp_q.size() > 0; n++) begin
      check("drain_valid", {15'h0, tx_valid}, 16'h1);
      check("drain_data", {8'h00, tx_data}, {8'h00, exp_q.pop_front()});
      @(posedge i_clk);
      #1;
    end
    check("drain_empty", {15'h0, tx_valid}, 16'h0);
    tx_ready = 1'b0;

    // Timer IRQ, period reload+1
    bus_write(16'hD002, 8'h03);
    bus_write(16'hD003, 8'h00);
    bus_write(16'hD004, 8'h03);
    repeat (3) @(posedge i_clk);
    #1;
    check("irq_before_expiry", {15'h0, IRQ}, 16'h0);
    @(posedge i_clk);
    #1;
    check("irq_first_expiry", {15'h0, IRQ}, 16'h1);
    bus_write(16'hD005, 8'hFF);
    check("irq_cleared", {15'h0, IRQ}, 16'h0);
    repeat (2) begin
      @(posedge i_clk);
      #1;
      check("irq_stays_clear", {15'h0, IRQ}, 16'h0);
    end
    @(posedge i_clk);
    #1;
    check("irq_second_expiry", {15'h0, IRQ}, 16'h1);
    bus_write(16'hD004, 8'h01);
    check("irq_masked", {15'h0, IRQ}, 16'h0);
    bus_write(16'hD005, 8'h00);
    read_check("status_pend_clear", 16'hD001, 8'h02);
    repeat (2) @(posedge i_clk);
    read_check("status_pend_masked", 16'hD001, 8'h82);
    check("irq_masked_still", {15'h0, IRQ}, 16'h0);
    bus_write(16'hD004, 8'h00);
    bus_write(16'hD005, 8'h00);

    // Async reset in the middle of a stall
    for (int i = 0; i < 8; i++) tx_write(8'h10 + 8'(i));
    bus_write(16'hD002, 8'h01);
    bus_write(16'hD004, 8'h03);
    irq_seen = 1'b0;
    for (int n = 0; n < 10 && !irq_seen; n++) begin
      @(posedge i_clk);
      #1;
      irq_seen = IRQ;
    end
    check("irq_before_reset", {15'h0, irq_seen}, 16'h1);
    @(negedge i_clk);
    addr = 16'hD000;
    dor  = 8'hAA;
    RW   = 1'b0;
    #1;
    check("pre_reset_stall", {15'h0, READY}, 16'h0);
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_reset_ready", {15'h0, READY}, 16'h1);
    check("mid_reset_tx_valid", {15'h0, tx_valid}, 16'h0);
    check("mid_reset_irq", {15'h0, IRQ}, 16'h0);
    check("mid_reset_din", {8'h00, din}, 16'h0000);
    RW   = 1'b1;
    addr = IDLE_ADDR;
    exp_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    read_check("post_reset_status", 16'hD001, 8'h02);
    read_check("post_reset_ctrl", 16'hD004, 8'h00);
    read_check("post_reset_ram", 16'h0010, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
